// File: rtl/tqvp_seq_pkg.sv
// ============================================================================
// Module      : tqvp_seq_pkg
// Description : Register map, control/status bit positions and shared types
//               for the PMOD pattern sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tqvp_seq_pkg;

  localparam logic [5:0] ADDR_CTRL     = 6'h00;
  localparam logic [5:0] ADDR_PRESCALE = 6'h04;
  localparam logic [5:0] ADDR_LENGTH   = 6'h08;
  localparam logic [5:0] ADDR_REPEAT   = 6'h0C;
  localparam logic [5:0] ADDR_IDLE     = 6'h10;
  localparam logic [5:0] ADDR_STATUS   = 6'h14;
  localparam logic [5:0] ADDR_PATTERN  = 6'h20;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_DONE       = 1;
  localparam int STAT_INDEX_LSB  = 4;
  localparam int STAT_REMAIN_LSB = 8;

  typedef enum logic [1:0] {
    XFER_BYTE = 2'b00,
    XFER_HALF = 2'b01,
    XFER_WORD = 2'b10,
    XFER_NONE = 2'b11
  } xfer_size_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Narrow writes only replace the low byte/half of the existing value.
  function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size);
    case (size)
      XFER_BYTE: merge_write = {old_val[31:8], wdata[7:0]};
      XFER_HALF: merge_write = {old_val[31:16], wdata[15:0]};
      default:   merge_write = wdata;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tqvp_seq_tick.sv
// ============================================================================
// Module      : tqvp_seq_tick
// Description : Step prescaler; pulses tick once every period+1 enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tqvp_seq_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] r_count;

  assign tick = enable && !clear && (r_count == period);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tqvp_pmod_sequencer.sv
// ============================================================================
// Module      : tqvp_pmod_sequencer
// Description : Register-programmed byte pattern sequencer driving uo_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tqvp_pmod_sequencer
  import tqvp_seq_pkg::*;
#(
  parameter int NSTEPS     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready
);

  localparam int IDX_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [6:0] PAT_END = 7'(ADDR_PATTERN) + 7'(NSTEPS);

  seq_state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_index, w_index_nxt, w_index_inc;
  logic [7:0]            r_remain, w_remain_nxt;
  logic                  r_done, w_done_nxt;
  logic [7:0]            r_uo, w_uo_nxt;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [IDX_W-1:0]      r_length;
  logic [7:0]            r_repeat;
  logic [7:0]            r_idle;
  logic                  r_loop;
  logic [7:0]            r_pattern [NSTEPS];

  logic                  w_wr, w_wr_ctrl, w_wr_pat, w_start, w_stop;
  logic                  w_busy, w_tick, w_pat_hit;
  logic [IDX_W-1:0]      w_pat_idx;
  logic [7:0]            w_idle_nxt;
  logic [31:0]           w_prescale_merged, w_status;
  logic                  w_unused_ok;

  assign w_unused_ok = ^{ui_in, data_read_n};
  assign data_ready  = 1'b1;
  assign uo_out      = r_uo;

  assign w_busy      = (r_state == ST_RUN);
  assign w_wr        = (data_write_n != XFER_NONE);
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_start     = w_wr_ctrl && data_in[CTRL_START] && !data_in[CTRL_STOP];
  assign w_stop      = w_wr_ctrl && data_in[CTRL_STOP];
  assign w_pat_hit   = ({1'b0, address} >= 7'(ADDR_PATTERN)) && ({1'b0, address} < PAT_END);
  assign w_pat_idx   = IDX_W'(address - ADDR_PATTERN);
  assign w_wr_pat    = w_wr && w_pat_hit;
  assign w_index_inc = r_index + 1'b1;
  assign w_idle_nxt  = (w_wr && address == ADDR_IDLE) ? data_in[7:0] : r_idle;
  assign w_prescale_merged = merge_write(32'(r_prescale), data_in, data_write_n);

  tqvp_seq_tick #(
    .W (PRESCALE_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!w_busy || w_stop),
    .enable (w_busy),
    .period (r_prescale),
    .tick   (w_tick)
  );

  // Timing/length/repeat are frozen while a sequence is running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prescale <= '0;
      r_length   <= '0;
      r_repeat   <= '0;
      r_idle     <= '0;
      r_loop     <= 1'b0;
    end else begin
      r_idle <= w_idle_nxt;
      if (w_wr_ctrl) r_loop <= data_in[CTRL_LOOP];
      if (w_wr && !w_busy) begin
        if (address == ADDR_PRESCALE) r_prescale <= w_prescale_merged[PRESCALE_W-1:0];
        if (address == ADDR_LENGTH)   r_length   <= data_in[IDX_W-1:0];
        if (address == ADDR_REPEAT)   r_repeat   <= data_in[7:0];
      end
    end
  end

  for (genvar i = 0; i < NSTEPS; i++) begin : g_pattern
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_pattern[i] <= 8'h00;
      end else if (w_wr_pat && (w_pat_idx == IDX_W'(i))) begin
        r_pattern[i] <= data_in[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_index  <= '0;
      r_remain <= '0;
      r_done   <= 1'b0;
      r_uo     <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_index  <= w_index_nxt;
      r_remain <= w_remain_nxt;
      r_done   <= w_done_nxt;
      r_uo     <= w_uo_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_index_nxt  = r_index;
    w_remain_nxt = r_remain;
    w_done_nxt   = r_done;
    w_uo_nxt     = r_uo;
    case (r_state)
      ST_IDLE: begin
        w_uo_nxt = w_idle_nxt;
        if (w_start) begin
          w_state_nxt  = ST_RUN;
          w_index_nxt  = '0;
          w_remain_nxt = r_repeat;
          w_done_nxt   = 1'b0;
          w_uo_nxt     = r_pattern[0];
        end
      end
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
          w_index_nxt = '0;
          w_done_nxt  = 1'b0;
          w_uo_nxt    = w_idle_nxt;
        end else if (w_tick) begin
          if (r_index != r_length) begin
            w_index_nxt = w_index_inc;
            w_uo_nxt    = r_pattern[w_index_inc];
          end else if (r_loop || r_remain != 8'h00) begin
            w_index_nxt = '0;
            w_uo_nxt    = r_pattern[0];
            if (!r_loop) w_remain_nxt = r_remain - 8'h01;
          end else begin
            w_state_nxt = ST_IDLE;
            w_index_nxt = '0;
            w_done_nxt  = 1'b1;
            w_uo_nxt    = w_idle_nxt;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY] = w_busy;
    w_status[STAT_DONE] = r_done;
    w_status[STAT_INDEX_LSB +: IDX_W] = r_index;
    w_status[STAT_REMAIN_LSB +: 8] = r_remain;
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:     data_out[CTRL_LOOP] = r_loop;
      ADDR_PRESCALE: data_out = 32'(r_prescale);
      ADDR_LENGTH:   data_out = 32'(r_length);
      ADDR_REPEAT:   data_out = 32'(r_repeat);
      ADDR_IDLE:     data_out = 32'(r_idle);
      ADDR_STATUS:   data_out = w_status;
      default:       if (w_pat_hit) data_out = 32'(r_pattern[w_pat_idx]);
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_tqvp_pmod_sequencer.sv
// ============================================================================
// Module      : tb_tqvp_pmod_sequencer
// Description : Directed self-checking bench for the PMOD pattern sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tqvp_pmod_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tqvp_pmod_sequencer #(
    .NSTEPS     (8),
    .PRESCALE_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ui_in        (ui_in),
    .uo_out       (uo_out),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the write lands.
  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address      = a;
    data_in      = d;
    data_write_n = sz;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, data_out, exp);
  endtask

  logic [7:0] pat   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] pat_m [4] = '{8'h11, 8'h22, 8'hAA, 8'h44};

  initial begin
    rst_n = 1'b0; ui_in = 8'h00; address = 6'h00; data_in = 32'h0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("reset_uo", {24'h0, uo_out}, 32'h0);
    check("data_ready", {31'h0, data_ready}, 32'h1);
    rd("reset_status", 6'h14, 32'h0);
    rd("reset_ctrl", 6'h00, 32'h0);

    // Write widths and unmapped read
    wr(6'h04, 32'hFFFF_FFFF, 2'b00);
    rd("prescale_byte", 6'h04, 32'h0000_00FF);
    wr(6'h04, 32'hFFFF_FFFF, 2'b01);
    rd("prescale_half", 6'h04, 32'h0000_FFFF);
    wr(6'h04, 32'hFFFF_FFFF, 2'b10);
    rd("prescale_word", 6'h04, 32'h0000_FFFF);
    wr(6'h08, 32'hFFFF_FFFF, 2'b00);
    rd("length_trunc", 6'h08, 32'h7);
    rd("unmapped_3c", 6'h3C, 32'h0);

    // Idle value follows the IDLE register
    wr(6'h10, 32'h0000_005A, 2'b00);
    check("idle_track", {24'h0, uo_out}, 32'h5A);

    // Single pass
    for (int i = 0; i < 4; i++) wr(6'(6'h20 + i), {24'h0, pat[i]}, 2'b00);
    rd("pattern2_rd", 6'h22, 32'h33);
    wr(6'h08, 32'h3, 2'b10);
    wr(6'h04, 32'h2, 2'b10);
    wr(6'h0C, 32'h0, 2'b10);
    wr(6'h00, 32'h1, 2'b00);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("pass1_uo_%0d", k), {24'h0, uo_out}, {24'h0, pat[k/3]});
      if (k == 4) rd("pass1_status_idx1", 6'h14, 32'h11);
      @(negedge clk);
    end
    check("pass1_end_uo", {24'h0, uo_out}, 32'h5A);
    rd("pass1_end_status", 6'h14, 32'h02);
    wr(6'h00, 32'h2, 2'b00);
    rd("stop_in_idle_done_sticky", 6'h14, 32'h02);

    // Two passes
    wr(6'h0C, 32'h1, 2'b00);
    wr(6'h00, 32'h1, 2'b00);
    rd("rep_status_start", 6'h14, 32'h0101);
    for (int k = 0; k < 24; k++) begin
      check($sformatf("rep_uo_%0d", k), {24'h0, uo_out}, {24'h0, pat[(k%12)/3]});
      if (k == 12) rd("rep_status_pass2", 6'h14, 32'h0001);
      @(negedge clk);
    end
    check("rep_end_uo", {24'h0, uo_out}, 32'h5A);
    rd("rep_end_status", 6'h14, 32'h02);

    // Locked config and live pattern edit while busy
    wr(6'h0C, 32'h0, 2'b00);
    wr(6'h00, 32'h1, 2'b00);
    wr(6'h04, 32'h0000_00FF, 2'b10);
    rd("busy_prescale_locked", 6'h04, 32'h2);
    wr(6'h00, 32'h1, 2'b00);
    wr(6'h22, 32'hAA, 2'b00);
    rd("busy_status_idx1", 6'h14, 32'h11);
    for (int k = 3; k < 12; k++) begin
      check($sformatf("busy_uo_%0d", k), {24'h0, uo_out}, {24'h0, pat_m[k/3]});
      @(negedge clk);
    end
    check("busy_end_uo", {24'h0, uo_out}, 32'h5A);
    wr(6'h22, 32'h33, 2'b00);

    // Loop forever, then stop
    wr(6'h08, 32'h1, 2'b00);
    wr(6'h04, 32'h0, 2'b10);
    wr(6'h00, 32'h5, 2'b00);
    rd("loop_ctrl_rd", 6'h00, 32'h4);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("loop_uo_%0d", k), {24'h0, uo_out}, (k % 2 == 0) ? 32'h11 : 32'h22);
      @(negedge clk);
    end
    wr(6'h00, 32'h2, 2'b00);
    check("stop_uo", {24'h0, uo_out}, 32'h5A);
    rd("stop_status", 6'h14, 32'h0);
    rd("stop_ctrl_rd", 6'h00, 32'h0);

    // Reset in the middle of a run
    wr(6'h08, 32'h3, 2'b00);
    wr(6'h04, 32'h2, 2'b00);
    wr(6'h00, 32'h1, 2'b00);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_run_uo", {24'h0, uo_out}, 32'h0);
    rd("rst_run_status", 6'h14, 32'h0);
    rd("rst_run_prescale", 6'h04, 32'h0);
    rd("rst_run_length", 6'h08, 32'h0);
    rd("rst_run_idle", 6'h10, 32'h0);
    rd("rst_run_pat0", 6'h20, 32'h0);
    repeat (4) @(negedge clk);
    check("rst_run_no_step", {24'h0, uo_out}, 32'h0);
    rd("rst_run_status_later", 6'h14, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tqvp_pmod_sequencer.md
TQVP_PMOD_SEQUENCER -- requirements
Module: tqvp_pmod_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  project clock (64 MHz nominal); rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: ui_in  in  8  synchronized PMOD inputs (unused); uo_out  out  8  sequenced output pattern.
REQ-003 SHALL have ports: address  in  6  register offset; data_in  in  32  write data; data_write_n  in  2  11 none/00 byte/01 half/10 word; data_read_n  in  2  same encoding for reads.
REQ-004 SHALL have ports: data_out  out  32  read data; data_ready  out  1  read complete.
REQ-005 SHALL use parameters: NSTEPS, 8, pattern buffer depth; PRESCALE_W, 16, prescaler width.

Function
REQ-006 Register map SHALL be: 0x00 CTRL (W: bit0 start, bit1 stop, bit2 loop_forever); 0x04 PRESCALE[15:0]; 0x08 LENGTH[2:0] (steps-1); 0x0C REPEAT[7:0] (passes-1); 0x10 IDLE[7:0]; 0x14 STATUS (RO); 0x20-0x27 PATTERN[0..7], one byte each.
REQ-007 Writes SHALL honour width: byte writes update [7:0], half [15:0], word [31:0]; bits beyond a register's width ignored.
REQ-008 STATUS SHALL read {16'h0, remaining_passes[7:0], 1'b0, index[2:0], 2'b0, done, busy}.
REQ-009 Reads of any register SHALL return its stored value, zero-extended; unmapped addresses read 0; CTRL reads {29'h0, loop_forever, 2'b0}.
REQ-010 data_ready SHALL be constant 1; reads have no side effects.
REQ-011 FSM SHALL have states IDLE and RUN.
REQ-012 IDLE -> RUN on a CTRL write with start=1, stop=0: next cycle busy=1, done=0, index=0, prescaler count=0, remaining_passes=REPEAT, uo_out=PATTERN[0].
REQ-013 In RUN each step SHALL last exactly PRESCALE+1 clk cycles; at step expiry index increments and uo_out loads PATTERN[index+1] in the same cycle.
REQ-014 When the step with index==LENGTH expires: if loop_forever=1 or remaining_passes!=0, index wraps to 0 (remaining_passes decrements unless loop_forever); otherwise FSM enters IDLE, busy=0, done=1, uo_out=IDLE.
REQ-015 CTRL write with stop=1 (any start value) SHALL return to IDLE next cycle with done=0, busy=0, uo_out=IDLE; stop in IDLE has no effect.
REQ-016 Start while RUN SHALL be ignored; loop_forever bit SHALL update on every CTRL write in either state.
REQ-017 Writes to PRESCALE, LENGTH, REPEAT while busy SHALL be ignored; PATTERN and IDLE writes SHALL always succeed, a PATTERN write taking effect at the next load of that index.
REQ-018 uo_out SHALL be registered; in IDLE it SHALL track IDLE register one cycle after a write.
REQ-019 done SHALL be sticky until the next accepted start or reset.

Reset
REQ-020 On rst_n=0 at a clk edge: state=IDLE, busy=0, done=0, index=0, prescaler=0, remaining_passes=0, all config registers and PATTERN bytes =0, loop_forever=0, uo_out=0.
REQ-021 Reset asserted mid-RUN SHALL abort the sequence with no further step.

Structure
REQ-022 Register offsets and STATUS bit positions SHALL be localparams in a shared include/package tqvp_seq_pkg.
REQ-023 Prescaler SHALL be sub-module tqvp_seq_tick (inputs clear, enable, period; output one-cycle tick).
REQ-024 Implementation SHALL be 120-400 lines, single clock, no latches.

Verification
REQ-025 PATTERN[0..3]=0x11,0x22,0x33,0x44, LENGTH=3, PRESCALE=2, REPEAT=0, start -> uo_out 0x11,0x22,0x33,0x44 for 3 cycles each, then IDLE value, STATUS=0x02.
REQ-026 Same with REPEAT=1 -> two passes (24 cycles RUN), remaining_passes reads 1 then 0, done set after pass 2.
REQ-027 loop_forever=1, LENGTH=1, PRESCALE=0 -> uo_out alternates PATTERN[0]/[1] every cycle indefinitely; CTRL write 0x2 -> uo_out=IDLE next cycle, done=0.
REQ-028 While busy write PRESCALE=0x00FF and start -> readback unchanged, step timing unchanged; PATTERN[2]=0xAA write mid-run -> 0xAA appears at next index-2 load.
REQ-029 Assert rst_n=0 during RUN -> next cycle uo_out=0, STATUS=0, all registers read 0.
REQ-030 Byte write 0xFFFFFFFF to PRESCALE -> reads 0x000000FF; half-word -> 0x0000FFFF; unmapped 0x3C reads 0.
